// File: rtl/ext_pulse_out_pkg.sv
// Shared types and helpers for the external pulse transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ext_pulse_out_pkg;

    // Pulse-shaping FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RECOVER = 2'd2
    } pulse_state_t;

    // Shortest active/recovery phase the far-end 4-tap synchroniser is guaranteed to see
    localparam int MIN_W_DEF = 4;

    // True when this accepted pulse produces a prescaled event.
    // ps=0: every accepted pulse. ps=k: bit k-1 of the counter rises 0->1 on this increment.
    // Only the low 7 counter bits can matter because ps selects at most bit 6.
    function automatic logic ps_bit_rises(input logic [6:0] cnt_lo, input logic [2:0] ps);
        logic [6:0] nxt;
        logic [2:0] idx;
        nxt = cnt_lo + 7'd1;
        idx = ps - 3'd1;
        if (ps == 3'd0) begin
            return 1'b1;
        end
        return (!cnt_lo[idx]) && nxt[idx];
    endfunction

endpackage

// File: rtl/ext_event_prescaler.sv
// Counts accepted timer strobes and flags every 2^ps-th one as an output event.
// Latency: combinational; evt is valid in the same cycle as the accepted strobe.
// Backpressure: none; strobes with en low are ignored and the count holds.
module ext_event_prescaler
    import ext_pulse_out_pkg::*;
#(
    parameter int CNT_W = 8  // must be >= 7 so every ps setting has a counter bit
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       en,
    input  logic       in_pulse,
    input  logic [2:0] ps,
    output logic       evt
);

    logic [CNT_W-1:0] ps_cnt;
    logic             accept;

    assign accept = en && in_pulse;

    // Free-running count of accepted strobes; changing ps never clears it
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ps_cnt <= '0;
        end else if (accept) begin
            ps_cnt <= ps_cnt + CNT_W'(1);
        end
    end

    assign evt = accept && ps_bit_rises(ps_cnt[6:0], ps);

endmodule

// File: rtl/ext_pulse_out.sv
// Turns prescaled timer events into a clean external clock/pulse waveform on a pin.
// Latency: strobe sampled at edge t with an idle FSM moves clk_ext_out at edge t+1.
// Backpressure: events queue in a saturating counter; overflow beyond the max is flagged sticky.
module ext_pulse_out
    import ext_pulse_out_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int PEND_W = 4,
    parameter int MIN_W  = MIN_W_DEF
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       en,
    input  logic       in_pulse,
    input  logic [2:0] ps,
    input  logic       edge_mode,
    input  logic [7:0] hold,
    input  logic       ovf_clr,
    output logic       clk_ext_out,
    output logic       busy,
    output logic       overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        MIN_W_V  = 8'(MIN_W);

    pulse_state_t      state;
    logic [PEND_W-1:0] pending;
    logic [7:0]        phase_cnt;
    logic [7:0]        w_lat;
    logic              pol_lat;
    logic [7:0]        w_req;
    logic              evt;
    logic              start;

    ext_event_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .pclk     (pclk),
        .preset   (preset),
        .en       (en),
        .in_pulse (in_pulse),
        .ps       (ps),
        .evt      (evt)
    );

    // Requested widths below the receiver's minimum are stretched up to it
    assign w_req = (hold < MIN_W_V) ? MIN_W_V : hold;

    // A pulse starts from IDLE, or straight out of a finished recovery phase, whenever work is queued
    always_comb begin
        start = 1'b0;
        if (pending != '0) begin
            if (state == ST_IDLE) begin
                start = 1'b1;
            end else if ((state == ST_RECOVER) && (phase_cnt == 8'd0)) begin
                start = 1'b1;
            end
        end
    end

    // Saturating queue of events not yet turned into pulses
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pending <= '0;
        end else begin
            case ({evt, start})
                2'b10: begin
                    if (pending != PEND_MAX) begin
                        pending <= pending + PEND_W'(1);
                    end
                end
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Sticky overflow; a new loss in the same cycle as a clear keeps it set
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            overflow <= 1'b0;
        end else if (evt && !start && (pending == PEND_MAX)) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Pulse shaper: width and polarity latched at ACTIVE entry so mid-pulse changes wait for the next pulse
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= ST_IDLE;
            clk_ext_out <= 1'b0;
            phase_cnt   <= 8'd0;
            w_lat       <= MIN_W_V;
            pol_lat     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_ACTIVE;
                        clk_ext_out <= ~edge_mode;
                        pol_lat     <= edge_mode;
                        w_lat       <= w_req;
                        phase_cnt   <= w_req - 8'd1;
                    end else begin
                        clk_ext_out <= edge_mode;
                    end
                end
                ST_ACTIVE: begin
                    if (phase_cnt == 8'd0) begin
                        state       <= ST_RECOVER;
                        clk_ext_out <= pol_lat;
                        phase_cnt   <= w_lat - 8'd1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                ST_RECOVER: begin
                    if (phase_cnt == 8'd0) begin
                        if (start) begin
                            state       <= ST_ACTIVE;
                            clk_ext_out <= ~edge_mode;
                            pol_lat     <= edge_mode;
                            w_lat       <= w_req;
                            phase_cnt   <= w_req - 8'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    clk_ext_out <= edge_mode;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_ext_pulse_out.sv
// Self-checking bench for ext_pulse_out: expected pulses are queued as stimulus is driven
// and compared against pulses captured from clk_ext_out.
// Outputs are sampled on the falling clock edge.
module tb_ext_pulse_out;

    logic       pclk = 1'b0;
    logic       preset;
    logic       en;
    logic       in_pulse;
    logic [2:0] ps;
    logic       edge_mode;
    logic [7:0] hold;
    logic       ovf_clr;
    logic       clk_ext_out;
    logic       busy;
    logic       overflow;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    logic mon_en    = 1'b0;
    logic mon_pol   = 1'b0;
    logic mon_act   = 1'b0;
    int   mon_start = 0;

    always #5 pclk = ~pclk;

    ext_pulse_out dut (
        .pclk        (pclk),
        .preset      (preset),
        .en          (en),
        .in_pulse    (in_pulse),
        .ps          (ps),
        .edge_mode   (edge_mode),
        .hold        (hold),
        .ovf_clr     (ovf_clr),
        .clk_ext_out (clk_ext_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    // One clock: cyc equals the number of rising edges seen; captures finished pulses
    task automatic tick();
        @(negedge pclk);
        cyc++;
        if (!mon_en) begin
            mon_act = 1'b0;
        end else if (!mon_act && (clk_ext_out !== mon_pol)) begin
            mon_act   = 1'b1;
            mon_start = cyc;
        end else if (mon_act && (clk_ext_out === mon_pol)) begin
            mon_act = 1'b0;
            obs_q.push_back('{mon_start, cyc - mon_start});
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Single strobe; on return cyc is the edge that sampled it
    task automatic pulse_once();
        in_pulse = 1'b1;
        tick();
        in_pulse = 1'b0;
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_pulse = 1'b0;
        ovf_clr  = 1'b0;
        preset   = 1'b1;
        tick();
        preset = 1'b0;
        ticks(2);
        obs_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        preset    = 1'b1;
        en        = 1'b0;
        in_pulse  = 1'b0;
        ps        = 3'd0;
        edge_mode = 1'b1;
        hold      = 8'd0;
        ovf_clr   = 1'b0;
        #1;
        checks++; if (clk_ext_out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", clk_ext_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        tick();
        preset = 1'b0;
        tick();
        checks++; if (clk_ext_out !== 1'b1) begin errors++; $display("FAIL reset_first_idle got=%b exp=1", clk_ext_out); end
        edge_mode = 1'b0;
        tick();
        checks++; if (clk_ext_out !== 1'b0) begin errors++; $display("FAIL reset_idle_follow got=%b exp=0", clk_ext_out); end
        mon_pol = 1'b0;
    endtask

    task automatic test_single();
        pulse_t e, o;
        int t;
        ps = 3'd0; hold = 8'd0; edge_mode = 1'b0; en = 1'b1; mon_pol = 1'b0;
        do_reset();
        ticks(3);
        pulse_once();
        t = cyc;
        exp_q.push_back('{t + 1, 4});
        ticks(8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got=%b exp=1 cyc=%0d", busy, cyc); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got=%b exp=0 cyc=%0d", busy, cyc); end
        ticks(4);
        // strobe with en low must produce nothing
        en = 1'b0;
        pulse_once();
        en = 1'b1;
        ticks(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL single_missing exp start=%0d width=%0d", e.start, e.width);
            end else begin
                o = obs_q.pop_front();
                if ((o.start !== e.start) || (o.width !== e.width)) begin
                    errors++; $display("FAIL single_pulse got start=%0d width=%0d exp start=%0d width=%0d", o.start, o.width, e.start, e.width);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra got=%0d extra pulses exp=0", obs_q.size()); end
    endtask

    task automatic test_prescale();
        pulse_t e, o;
        ps = 3'd2; hold = 8'd2; edge_mode = 1'b0; en = 1'b1; mon_pol = 1'b0;
        do_reset();
        ticks(2);
        for (int i = 1; i <= 8; i++) begin
            pulse_once();
            if ((i == 2) || (i == 6)) exp_q.push_back('{cyc + 1, 4});
            ticks(11);
            en = 1'b0;
            pulse_once();
            en = 1'b1;
            ticks(2);
        end
        ticks(10);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL prescale_missing exp start=%0d width=%0d", e.start, e.width);
            end else begin
                o = obs_q.pop_front();
                if ((o.start !== e.start) || (o.width !== e.width)) begin
                    errors++; $display("FAIL prescale_pulse got start=%0d width=%0d exp start=%0d width=%0d", o.start, o.width, e.start, e.width);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL prescale_extra got=%0d extra pulses exp=0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        pulse_t e, o;
        int t0;
        ps = 3'd0; hold = 8'd0; edge_mode = 1'b0; en = 1'b1; mon_pol = 1'b0;
        do_reset();
        ticks(2);
        t0 = cyc + 1;
        for (int k = 0; k < 18; k++) exp_q.push_back('{t0 + 1 + 8 * k, 4});
        in_pulse = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc == t0 + 17) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_early got=%b exp=0", overflow); end
            end
            if (cyc == t0 + 18) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf_set got=%b exp=1", overflow); end
            end
        end
        in_pulse = 1'b0;
        ticks(160);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drained got busy=%b exp=0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_missing exp start=%0d width=%0d", e.start, e.width);
            end else begin
                o = obs_q.pop_front();
                if ((o.start !== e.start) || (o.width !== e.width)) begin
                    errors++; $display("FAIL b2b_pulse got start=%0d width=%0d exp start=%0d width=%0d", o.start, o.width, e.start, e.width);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got=%0d extra pulses exp=0", obs_q.size()); end
    endtask

    task automatic test_edge_mode();
        pulse_t e, o;
        int ta;
        ps = 3'd0; hold = 8'd10; edge_mode = 1'b1; en = 1'b1; mon_pol = 1'b1;
        do_reset();
        ticks(2);
        in_pulse = 1'b1;
        tick();
        ta = cyc;
        tick();
        in_pulse = 1'b0;
        // first pulse keeps width 10; the queued one latches the new hold at its start
        exp_q.push_back('{ta + 1, 10});
        exp_q.push_back('{ta + 21, 5});
        ticks(3);
        hold = 8'd5;
        checks++; if (clk_ext_out !== 1'b0) begin errors++; $display("FAIL edge_active_low got=%b exp=0", clk_ext_out); end
        ticks(11);
        checks++; if (clk_ext_out !== 1'b1) begin errors++; $display("FAIL edge_recover_high got=%b exp=1", clk_ext_out); end
        ticks(30);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_drained got busy=%b exp=0", busy); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL edge_missing exp start=%0d width=%0d", e.start, e.width);
            end else begin
                o = obs_q.pop_front();
                if ((o.start !== e.start) || (o.width !== e.width)) begin
                    errors++; $display("FAIL edge_pulse got start=%0d width=%0d exp start=%0d width=%0d", o.start, o.width, e.start, e.width);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL edge_extra got=%0d extra pulses exp=0", obs_q.size()); end
        mon_en = 1'b0;
        edge_mode = 1'b0;
        mon_pol = 1'b0;
        ticks(2);
    endtask

    task automatic test_reset_mid();
        ps = 3'd0; hold = 8'd0; edge_mode = 1'b0; en = 1'b1; mon_pol = 1'b0;
        do_reset();
        ticks(2);
        in_pulse = 1'b1;
        ticks(4);
        in_pulse = 1'b0;
        mon_en = 1'b0;
        checks++; if (clk_ext_out !== 1'b1) begin errors++; $display("FAIL rstmid_active got=%b exp=1", clk_ext_out); end
        #1;
        preset = 1'b1;
        #1;
        checks++; if (clk_ext_out !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%b exp=0", clk_ext_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tick();
        preset = 1'b0;
        ticks(2);
        obs_q.delete();
        mon_en = 1'b1;
        ticks(60);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_pulses got=%0d pulses exp=0", obs_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_ovf_clr();
        int t0;
        ps = 3'd0; hold = 8'd200; edge_mode = 1'b0; en = 1'b1; mon_pol = 1'b0;
        do_reset();
        ticks(2);
        t0 = cyc + 1;
        in_pulse = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (cyc == t0 + 15) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
        in_pulse = 1'b0;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
        ovf_clr = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got=%b exp=1", busy); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_prescale();
        test_back_to_back();
        test_edge_mode();
        test_reset_mid();
        test_ovf_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
